// File: rtl/controller_pkg.sv
// Shared constants for the micro-operation sequencer and the controller ROM.
// Holds the sequencer state encoding and the fixed uOP step indices that
// both blocks must agree on.
package controller_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    EXEC     = 2'b01,
    FAULT_ST = 2'b10
  } seq_state_t;

  localparam logic [2:0] UOP_FETCH      = 3'd0;
  localparam logic [2:0] UOP_DECODE     = 3'd1;
  localparam logic [2:0] UOP_FIRST_EXEC = 3'd2;
  localparam logic [2:0] UOP_IDLE       = 3'd7;

endpackage

// File: rtl/uop_sequencer_if.sv
// Signal bundle between the sequencer and its surroundings (run control,
// controller ROM, ALU).
// Ports (slave = sequencer side):
//   in : RUN, STEP, HALT_REQ, CLR_FAULT, RESET_uOP, READ_FLAGS, ALU_ZERO, ALU_COUT
//   out: uOP, ZERO_FLAG, COUT_FLAG, INSTR_DONE, HALTED, FAULT, INSTR_COUNT,
//        dbg_state (current FSM state, for observation only)
// Handshake semantics: there is no valid/ready pair on this bundle. Every
// input is a level sampled on the rising clock edge (STEP is edge-detected
// inside the sequencer); every output is registered and changes only on the
// rising edge or on asynchronous reset.
interface uop_sequencer_if
  import controller_pkg::*;
#(
  parameter int COUNT_W = 16
);
  logic               RUN;
  logic               STEP;
  logic               HALT_REQ;
  logic               CLR_FAULT;
  logic               RESET_uOP;
  logic               READ_FLAGS;
  logic               ALU_ZERO;
  logic               ALU_COUT;
  logic [2:0]         uOP;
  logic               ZERO_FLAG;
  logic               COUT_FLAG;
  logic               INSTR_DONE;
  logic               HALTED;
  logic               FAULT;
  logic [COUNT_W-1:0] INSTR_COUNT;
  seq_state_t         dbg_state;

  modport slave (
    input  RUN, STEP, HALT_REQ, CLR_FAULT, RESET_uOP, READ_FLAGS, ALU_ZERO, ALU_COUT,
    output uOP, ZERO_FLAG, COUT_FLAG, INSTR_DONE, HALTED, FAULT, INSTR_COUNT, dbg_state
  );

  modport master (
    output RUN, STEP, HALT_REQ, CLR_FAULT, RESET_uOP, READ_FLAGS, ALU_ZERO, ALU_COUT,
    input  uOP, ZERO_FLAG, COUT_FLAG, INSTR_DONE, HALTED, FAULT, INSTR_COUNT, dbg_state
  );

endinterface

// File: rtl/uop_sequencer_flag_register.sv
// Two-bit architectural flag register {ZERO, COUT}.
// Ports: clk, rst_n (async active-low clear), load (capture enable),
//        d[1:0] (new flag values), q[1:0] (held flag values).
// Back-to-back loads each capture; the most recent one wins.
module flag_register (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [1:0] d,
  output logic [1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 2'b00;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/uop_sequencer.sv
// Micro-operation sequencer feeding the controller ROM.
// Generates the 3-bit uOP step index, retires instructions on RESET_uOP,
// holds the ZERO/COUT flag register, and provides run / halt / single-step
// control plus a trap for microcode that runs past MAX_UOP.
// Ports:
//   CLK   : system clock, rising edge
//   RST_N : asynchronous active-low reset
//   bus   : uop_sequencer_if slave modport (see the interface for signals)
// MAX_UOP must lie in 2..6 so that uOP 7 stays reserved as the idle step.
module uop_sequencer
  import controller_pkg::*;
#(
  parameter int MAX_UOP = 6,
  parameter int COUNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  uop_sequencer_if.slave   bus
);

  localparam logic [2:0] MAX_U = 3'(MAX_UOP);

  seq_state_t         state;
  logic [2:0]         uop_q;
  logic               done_q;
  logic               halted_q;
  logic               fault_q;
  logic [COUNT_W-1:0] count_q;
  logic               step_q;
  logic               step_rise;
  logic               run_ok;
  logic               retire;
  logic [1:0]         flags_q;

  // Single-step requests are levels; only a 0->1 transition starts work.
  assign step_rise = bus.STEP & ~step_q;
  assign run_ok    = bus.RUN & ~bus.HALT_REQ;

  // RESET_uOP is meaningless during fetch/decode and at the idle step.
  assign retire = (state == EXEC) && (uop_q >= UOP_FIRST_EXEC) &&
                  (uop_q <= MAX_U) && bus.RESET_uOP;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      step_q <= 1'b0;
    end else begin
      step_q <= bus.STEP;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      uop_q    <= UOP_IDLE;
      done_q   <= 1'b0;
      halted_q <= 1'b1;
      fault_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (run_ok || step_rise) begin
            state    <= EXEC;
            uop_q    <= UOP_FETCH;
            halted_q <= 1'b0;
          end else begin
            uop_q    <= UOP_IDLE;
            halted_q <= 1'b1;
          end
        end
        EXEC: begin
          if (retire) begin
            done_q  <= 1'b1;
            count_q <= count_q + 1'b1;
            // Free-running retirement goes straight into the next fetch.
            if (run_ok) begin
              uop_q <= UOP_FETCH;
            end else begin
              state    <= IDLE;
              uop_q    <= UOP_IDLE;
              halted_q <= 1'b1;
            end
          end else if (uop_q >= MAX_U) begin
            // Microcode reached its last legal step without ending.
            state   <= FAULT_ST;
            uop_q   <= UOP_IDLE;
            fault_q <= 1'b1;
          end else begin
            uop_q <= uop_q + 3'd1;
          end
        end
        FAULT_ST: begin
          uop_q <= UOP_IDLE;
          if (bus.CLR_FAULT) begin
            state    <= IDLE;
            fault_q  <= 1'b0;
            halted_q <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          uop_q    <= UOP_IDLE;
          halted_q <= 1'b1;
          fault_q  <= 1'b0;
        end
      endcase
    end
  end

  flag_register u_flags (
    .clk   (CLK),
    .rst_n (RST_N),
    .load  (bus.READ_FLAGS),
    .d     ({bus.ALU_ZERO, bus.ALU_COUT}),
    .q     (flags_q)
  );

  assign bus.uOP         = uop_q;
  assign bus.ZERO_FLAG   = flags_q[1];
  assign bus.COUT_FLAG   = flags_q[0];
  assign bus.INSTR_DONE  = done_q;
  assign bus.HALTED      = halted_q;
  assign bus.FAULT       = fault_q;
  assign bus.INSTR_COUNT = count_q;
  assign bus.dbg_state   = state;

endmodule

// File: tb/tb_uop_sequencer.sv
// Directed bench for uop_sequencer. A tiny ROM stand-in drives RESET_uOP,
// READ_FLAGS and the ALU flags from per-step tables indexed by uOP.
module tb_uop_sequencer;
  import controller_pkg::*;

  localparam int COUNT_W = 4;

  logic CLK;
  logic RST_N;
  int   checks;
  int   failures;

  logic [7:0] rst_mask;
  logic [7:0] read_mask;
  logic [7:0] zero_tab;
  logic [7:0] cout_tab;

  uop_sequencer_if #(.COUNT_W(COUNT_W)) sif ();

  uop_sequencer #(.MAX_UOP(6), .COUNT_W(COUNT_W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (sif.slave)
  );

  // Clock / reset block
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Controller ROM stand-in
  always_comb begin
    sif.RESET_uOP  = rst_mask[sif.uOP];
    sif.READ_FLAGS = read_mask[sif.uOP];
    sif.ALU_ZERO   = zero_tab[sif.uOP];
    sif.ALU_COUT   = cout_tab[sif.uOP];
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    #2;
    RST_N = 1'b0;
    #7;
    RST_N = 1'b1;
    tick();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    RST_N     = 1'b0;
    sif.RUN       = 1'b0;
    sif.STEP      = 1'b0;
    sif.HALT_REQ  = 1'b0;
    sif.CLR_FAULT = 1'b0;
    rst_mask  = 8'h00;
    read_mask = 8'h00;
    zero_tab  = 8'h00;
    cout_tab  = 8'h00;

    // ---- reset values
    tick();
    tick();
    RST_N = 1'b1;
    tick();
    chk("rst_uop",    32'(sif.uOP), 32'd7);
    chk("rst_halted", 32'(sif.HALTED), 32'd1);
    chk("rst_fault",  32'(sif.FAULT), 32'd0);
    chk("rst_done",   32'(sif.INSTR_DONE), 32'd0);
    chk("rst_count",  32'(sif.INSTR_COUNT), 32'd0);
    chk("rst_flags",  32'({sif.ZERO_FLAG, sif.COUT_FLAG}), 32'd0);
    chk("rst_state",  32'(sif.dbg_state), 32'(IDLE));

    // ---- free run, RESET_uOP at uOP 3: 0,1,2,3,0,1,2,3,...
    rst_mask = 8'b0000_1000;
    sif.RUN  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      for (int u = 0; u < 4; u++) begin
        tick();
        chk("run_uop",  32'(sif.uOP), 32'(u));
        chk("run_done", 32'(sif.INSTR_DONE), (u == 0 && i > 0) ? 32'd1 : 32'd0);
      end
    end
    tick();
    chk("run_uop_wrap", 32'(sif.uOP), 32'd0);
    chk("run_done3",    32'(sif.INSTR_DONE), 32'd1);
    chk("run_count3",   32'(sif.INSTR_COUNT), 32'd3);
    sif.RUN = 1'b0;

    // ---- single step, RESET_uOP at uOP 5
    do_reset();
    rst_mask = 8'b0010_0000;
    for (int p = 0; p < 2; p++) begin
      sif.STEP = 1'b1;
      for (int u = 0; u < 6; u++) begin
        tick();
        if (u == 0) sif.STEP = 1'b0;
        chk("step_uop",    32'(sif.uOP), 32'(u));
        chk("step_halted", 32'(sif.HALTED), 32'd0);
      end
      tick();
      chk("step_end_uop", 32'(sif.uOP), 32'd7);
      chk("step_done",    32'(sif.INSTR_DONE), 32'd1);
      chk("step_halted1", 32'(sif.HALTED), 32'd1);
      chk("step_count",   32'(sif.INSTR_COUNT), 32'(p + 1));
      tick();
      tick();
      chk("step_park_uop", 32'(sif.uOP), 32'd7);
      chk("step_park_done", 32'(sif.INSTR_DONE), 32'd0);
    end

    // ---- HALT_REQ at uOP 1; RESET_uOP also offered at uOP 0/1 (ignored)
    do_reset();
    rst_mask = 8'b0001_0011;
    sif.RUN  = 1'b1;
    tick();
    chk("halt_uop0", 32'(sif.uOP), 32'd0);
    tick();
    chk("halt_uop1", 32'(sif.uOP), 32'd1);
    sif.HALT_REQ = 1'b1;
    for (int u = 2; u < 5; u++) begin
      tick();
      chk("halt_uop", 32'(sif.uOP), 32'(u));
    end
    tick();
    chk("halt_end_uop", 32'(sif.uOP), 32'd7);
    chk("halt_halted",  32'(sif.HALTED), 32'd1);
    chk("halt_count",   32'(sif.INSTR_COUNT), 32'd1);
    tick();
    tick();
    chk("halt_blocks_run", 32'(sif.uOP), 32'd7);
    // A STEP edge still runs one instruction under HALT_REQ.
    sif.STEP = 1'b1;
    tick();
    sif.STEP = 1'b0;
    chk("halt_step_uop0", 32'(sif.uOP), 32'd0);
    repeat (4) tick();
    chk("halt_step_uop4", 32'(sif.uOP), 32'd4);
    tick();
    chk("halt_step_end", 32'(sif.uOP), 32'd7);
    chk("halt_step_cnt", 32'(sif.INSTR_COUNT), 32'd2);
    sif.HALT_REQ = 1'b0;
    sif.RUN      = 1'b0;

    // ---- runaway microcode: no RESET_uOP
    do_reset();
    rst_mask = 8'h00;
    sif.STEP = 1'b1;
    tick();
    sif.STEP = 1'b0;
    chk("flt_uop0", 32'(sif.uOP), 32'd0);
    repeat (6) tick();
    chk("flt_uop6",  32'(sif.uOP), 32'd6);
    chk("flt_pre",   32'(sif.FAULT), 32'd0);
    tick();
    chk("flt_uop7",  32'(sif.uOP), 32'd7);
    chk("flt_fault", 32'(sif.FAULT), 32'd1);
    chk("flt_count", 32'(sif.INSTR_COUNT), 32'd0);
    chk("flt_state", 32'(sif.dbg_state), 32'(FAULT_ST));
    sif.STEP = 1'b1;
    tick();
    sif.STEP = 1'b0;
    sif.RUN  = 1'b1;
    tick();
    chk("flt_ignore_uop",   32'(sif.uOP), 32'd7);
    chk("flt_ignore_fault", 32'(sif.FAULT), 32'd1);
    sif.RUN       = 1'b0;
    sif.CLR_FAULT = 1'b1;
    tick();
    sif.CLR_FAULT = 1'b0;
    chk("flt_clr_fault",  32'(sif.FAULT), 32'd0);
    chk("flt_clr_halted", 32'(sif.HALTED), 32'd1);
    chk("flt_clr_state",  32'(sif.dbg_state), 32'(IDLE));
    tick();
    chk("flt_idle_uop", 32'(sif.uOP), 32'd7);

    // ---- flag capture at uOP 4 then uOP 5; last capture wins and holds
    do_reset();
    rst_mask  = 8'b0100_0000;
    read_mask = 8'b0011_0000;
    zero_tab  = 8'b0001_0000;
    cout_tab  = 8'b0010_0000;
    sif.STEP  = 1'b1;
    tick();
    sif.STEP = 1'b0;
    repeat (4) tick();
    chk("flg_uop4",   32'(sif.uOP), 32'd4);
    chk("flg_before", 32'({sif.ZERO_FLAG, sif.COUT_FLAG}), 32'b00);
    tick();
    chk("flg_after4", 32'({sif.ZERO_FLAG, sif.COUT_FLAG}), 32'b10);
    tick();
    chk("flg_after5", 32'({sif.ZERO_FLAG, sif.COUT_FLAG}), 32'b01);
    tick();
    chk("flg_idle_uop", 32'(sif.uOP), 32'd7);
    zero_tab = 8'hFF;
    cout_tab = 8'h00;
    repeat (3) tick();
    chk("flg_held", 32'({sif.ZERO_FLAG, sif.COUT_FLAG}), 32'b01);

    // ---- 4-bit counter wrap over 17 three-step instructions, then async reset
    do_reset();
    chk("wrap_flags_cleared", 32'({sif.ZERO_FLAG, sif.COUT_FLAG}), 32'b00);
    rst_mask  = 8'b0000_0100;
    read_mask = 8'b0000_0010;
    zero_tab  = 8'b0000_0010;
    cout_tab  = 8'b0000_0010;
    sif.RUN   = 1'b1;
    tick();
    chk("wrap_start", 32'(sif.uOP), 32'd0);
    repeat (48) tick();
    chk("wrap_count16", 32'(sif.INSTR_COUNT), 32'd0);
    repeat (3) tick();
    chk("wrap_count17", 32'(sif.INSTR_COUNT), 32'd1);
    chk("wrap_done",    32'(sif.INSTR_DONE), 32'd1);
    tick();
    tick();
    chk("ar_uop2",  32'(sif.uOP), 32'd2);
    chk("ar_flags", 32'({sif.ZERO_FLAG, sif.COUT_FLAG}), 32'b11);
    #3;
    RST_N = 1'b0;
    #1;
    chk("ar_uop_now",    32'(sif.uOP), 32'd7);
    chk("ar_flags_now",  32'({sif.ZERO_FLAG, sif.COUT_FLAG}), 32'b00);
    chk("ar_count_now",  32'(sif.INSTR_COUNT), 32'd0);
    chk("ar_halted_now", 32'(sif.HALTED), 32'd1);
    sif.RUN = 1'b0;
    #2;
    RST_N = 1'b1;
    tick();
    chk("ar_after_uop", 32'(sif.uOP), 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
